// File: rtl/mac_9x16_controller_pkg.sv
// Shared constants, state encoding and helpers for the 9-lane MAC controller.
package mac_9x16_controller_pkg;

    localparam int N           = 16;          // operand / product / result width
    localparam int Q           = 12;          // fractional bits (products arrive Q-aligned)
    localparam int LANES       = 9;           // multiplier lanes in the array
    localparam int ACC_W       = N + 4;       // 9 * (2^15) fits in N+4 signed bits
    localparam int ARM_TIMEOUT = 4;           // cycles to wait for mul_busy to rise

    localparam logic [2:0] ARM_LAST  = 3'(ARM_TIMEOUT - 1);
    localparam logic [3:0] LAST_LANE = 4'(LANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACC   = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Sign-extend one N-bit lane product to the accumulator width.
    function automatic logic signed [ACC_W-1:0] lane_ext(input logic [N-1:0] v);
        return {{(ACC_W-N){v[N-1]}}, v};
    endfunction

endpackage

// File: rtl/mac_9x16_controller_saturate.sv
// Combinational signed clamp from IN_W to OUT_W bits with a saturation flag.
module fixed_point_saturate #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  value,
    output logic        [OUT_W-1:0] clamped,
    output logic                    sat
);

    // Value fits when every bit from the output sign bit upward equals the input sign.
    always_comb begin
        clamped = value[OUT_W-1:0];
        sat     = 1'b0;
        if (value[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){value[IN_W-1]}}) begin
            clamped = value[OUT_W-1:0];
            sat     = 1'b0;
        end else if (value[IN_W-1]) begin
            clamped = {1'b1, {(OUT_W-1){1'b0}}};
            sat     = 1'b1;
        end else begin
            clamped = {1'b0, {(OUT_W-1){1'b1}}};
            sat     = 1'b1;
        end
    end

endmodule

// File: rtl/mac_9x16_controller.sv
// Initiator/consumer for the 9-lane multiplier array: latch operands, start the
// array, wait for completion, accumulate the 9 products serially and present a
// saturated sum on a valid/ready output.
module mac_9x16_controller
    import mac_9x16_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   a_flat,
    input  logic [LANES*N-1:0]   b_flat,
    output logic [LANES*N-1:0]   mul_a_flat,
    output logic [LANES*N-1:0]   mul_b_flat,
    output logic                 mul_start,
    input  logic                 mul_busy,
    input  logic [LANES*N-1:0]   mul_o_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_sum,
    output logic                 out_sat,
    output logic                 busy
);

    state_t                   state_r;
    state_t                   state_s;
    logic [2:0]               arm_cnt_r;
    logic [3:0]               lane_idx_r;
    logic [N-1:0]             prod_r [0:LANES-1];
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic [N-1:0]             clamp_s;
    logic                     clamp_sat_s;
    logic                     accept_s;
    logic                     capture_s;

    assign accept_s  = (state_r == ST_IDLE) && in_valid && in_ready;
    assign acc_sum_s = acc_r + lane_ext(prod_r[lane_idx_r]);

    fixed_point_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (N)
    ) u_sat (
        .value   (acc_sum_s),
        .clamped (clamp_s),
        .sat     (clamp_sat_s)
    );

    // Products are captured when the array finishes, or when it never armed.
    always_comb begin
        capture_s = 1'b0;
        if (state_r == ST_WAIT) begin
            capture_s = !mul_busy;
        end else if (state_r == ST_ARM) begin
            capture_s = !mul_busy && (arm_cnt_r == ARM_LAST);
        end else begin
            capture_s = 1'b0;
        end
    end

    // Next-state logic for the start/busy handshake and accumulation sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_START;
                else          state_s = ST_IDLE;
            end
            ST_START: begin
                state_s = ST_ARM;
            end
            ST_ARM: begin
                if (mul_busy)                     state_s = ST_WAIT;
                else if (arm_cnt_r == ARM_LAST)   state_s = ST_ACC;
                else                              state_s = ST_ARM;
            end
            ST_WAIT: begin
                if (mul_busy) state_s = ST_WAIT;
                else          state_s = ST_ACC;
            end
            ST_ACC: begin
                if (lane_idx_r == LAST_LANE) state_s = ST_OUT;
                else                         state_s = ST_ACC;
            end
            ST_OUT: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_OUT;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register; async reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Control outputs registered from the next state so they align with it.
    // in_ready also waits out an array left busy across a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_start <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            mul_start <= (state_s == ST_START);
            out_valid <= (state_s == ST_OUT);
            busy      <= (state_s != ST_IDLE);
            in_ready  <= (state_s == ST_IDLE) && !mul_busy;
        end
    end

    // Operand registers: written only on accept, so stable until capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_flat <= '0;
            mul_b_flat <= '0;
        end else if (accept_s) begin
            mul_a_flat <= a_flat;
            mul_b_flat <= b_flat;
        end
    end

    // ARM timeout counter and ACC lane index; both idle at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt_r  <= 3'd0;
            lane_idx_r <= 4'd0;
        end else begin
            arm_cnt_r  <= (state_r == ST_ARM) ? arm_cnt_r + 3'd1 : 3'd0;
            lane_idx_r <= ((state_r == ST_ACC) && (lane_idx_r != LAST_LANE))
                          ? lane_idx_r + 4'd1 : 4'd0;
        end
    end

    // Product capture from the array in the completion cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) prod_r[i] <= '0;
        end else if (capture_s) begin
            for (int i = 0; i < LANES; i++) prod_r[i] <= mul_o_flat[i*N +: N];
        end
    end

    // Serial accumulation; the clamped result is registered on the last lane
    // and the accumulator is cleared once the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= '0;
            out_sum <= '0;
            out_sat <= 1'b0;
        end else if (state_r == ST_ACC) begin
            acc_r <= acc_sum_s;
            if (lane_idx_r == LAST_LANE) begin
                out_sum <= clamp_s;
                out_sat <= clamp_sat_s;
            end
        end else if ((state_r == ST_OUT) && out_ready) begin
            acc_r <= '0;
        end
    end

endmodule

// File: tb/tb_mac_9x16_controller.sv
// Scoreboard bench for mac_9x16_controller with a behavioural multiplier array.
module tb_mac_9x16_controller;

    localparam int N  = 16;
    localparam int LN = 9;
    localparam int W  = N * LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_flat;
    logic [W-1:0]  b_flat;
    logic [W-1:0]  mul_a_flat;
    logic [W-1:0]  mul_b_flat;
    logic          mul_start;
    logic          mul_busy;
    logic [W-1:0]  mul_o_flat;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic          out_sat;
    logic          busy;

    mac_9x16_controller dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .mul_a_flat (mul_a_flat),
        .mul_b_flat (mul_b_flat),
        .mul_start  (mul_start),
        .mul_busy   (mul_busy),
        .mul_o_flat (mul_o_flat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_starts = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mul_start) n_starts <= n_starts + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural multiplier array (no reset) ----------------
    int            busy_len   = 3;
    logic          never_busy = 1'b0;
    int            mdl_cnt    = 0;
    logic [W-1:0]  mdl_prod   = '0;
    logic [W-1:0]  snap_a     = '0;
    logic [W-1:0]  snap_b     = '0;

    function automatic logic [N-1:0] qmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        p = p >>> 12;
        return p[N-1:0];
    endfunction

    always @(posedge clk) begin
        if (mul_start) begin
            for (int i = 0; i < LN; i++)
                mdl_prod[i*N +: N] <= qmul(mul_a_flat[i*N +: N], mul_b_flat[i*N +: N]);
            snap_a  <= mul_a_flat;
            snap_b  <= mul_b_flat;
            mdl_cnt <= never_busy ? 0 : busy_len;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign mul_busy   = (mdl_cnt != 0);
    assign mul_o_flat = mdl_prod;

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [N-1:0] sum;
        logic         sat;
        int           t0;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic         prev_hold = 1'b0;
    logic [N-1:0] held_sum;
    logic         held_sat;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (busy && mul_busy) begin
                    chk("mul_a_stable", 32'(mul_a_flat == snap_a), 32'd1);
                    chk("mul_b_stable", 32'(mul_b_flat == snap_b), 32'd1);
                end
                if (out_valid && prev_hold) begin
                    chk("out_sum_stable", 32'(out_sum), 32'(held_sum));
                    chk("out_sat_stable", 32'(out_sat), 32'(held_sat));
                end else if (out_valid && sb.size() != 0 && sb[0].lat != 0) begin
                    chk("latency", 32'(cyc - sb[0].t0), 32'(sb[0].lat));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'(out_sum), 32'hFFFF_FFFF);
                    end else begin
                        chk("out_sum", 32'(out_sum), 32'(sb[0].sum));
                        chk("out_sat", 32'(out_sat), 32'(sb[0].sat));
                        void'(sb.pop_front());
                    end
                end
                prev_hold = out_valid && !out_ready;
                held_sum  = out_sum;
                held_sat  = out_sat;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] fill(input logic [N-1:0] v);
        return {LN{v}};
    endfunction

    // Lanes 0..7 alternate +1.0/-1.0; lane 8 is +1.0 continuing the pattern plus 0.25.
    function automatic logic [W-1:0] alt_vec();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*N +: N] = (i % 2 == 0) ? 16'h1000 : 16'hF000;
        v[8*N +: N] = 16'h1400;
        return v;
    endfunction

    // Call at a negedge. Presents a set, waits for acceptance, pushes the
    // expected result, returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [N-1:0] esum, input logic esat,
                        input int lat, input logic keep);
        exp_t e;
        int   k;
        a_flat   = a;
        b_flat   = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            e.sum = esum;
            e.sat = esat;
            e.t0  = cyc;
            e.lat = lat;
            sb.push_back(e);
            @(negedge clk);
            if (!keep) in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        int k;
        int s0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_flat    = '0;
        b_flat    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_mul_a",     32'(mul_a_flat == '0), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // 1: 9 * (1.0 * 0.5) = 4.5
        send(fill(16'h1000), fill(16'h0800), 16'h4800, 1'b0, 15, 1'b0);
        drain();

        // 2: +9.0 and -9.0 saturate
        send(fill(16'h1000), fill(16'h1000), 16'h7FFF, 1'b1, 15, 1'b0);
        drain();
        send(fill(16'hF000), fill(16'h1000), 16'h8000, 1'b1, 15, 1'b0);
        drain();

        // 3: alternating lanes = 1.25, result held under backpressure
        out_ready = 1'b0;
        send(alt_vec(), fill(16'h1000), 16'h1400, 1'b0, 15, 1'b0);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_sum",   32'(out_sum),   32'h1400);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            chk("hold_busy",      32'(busy),      32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // 4: array never raises busy; 9 * (2.0 * -1/16) = -1.125
        never_busy = 1'b1;
        send(fill(16'h2000), fill(16'hFF00), 16'hEE00, 1'b0, 15, 1'b0);
        drain();
        never_busy = 1'b0;

        // 5: reset during WAIT while the array stays busy
        busy_len = 8;
        send(fill(16'h1000), fill(16'h0800), 16'h4800, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
        chk("mid_rst_mul_a",     32'(mul_a_flat == '0), 32'd1);
        chk("mid_rst_out_sum",   32'(out_sum),   32'd0);
        rst = 1'b0;
        chk("array_still_busy", 32'(mul_busy), 32'd1);
        k = 0;
        while (mul_busy && k < 50) begin
            chk("in_ready_while_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        busy_len = 3;
        send(fill(16'h1000), fill(16'h0800), 16'h4800, 1'b0, 15, 1'b0);
        drain();

        // 6: back-to-back sets with in_valid held high
        s0 = n_starts;
        send(fill(16'h1000), fill(16'h0800), 16'h4800, 1'b0, 15, 1'b1);
        send(alt_vec(),      fill(16'h1000), 16'h1400, 1'b0, 15, 1'b1);
        send(fill(16'h2000), fill(16'hFF00), 16'hEE00, 1'b0, 15, 1'b0);
        drain();
        chk("start_pulses", 32'(n_starts - s0), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
